// File: rtl/sequenciador_rega.sv
// Irrigation cycle scheduler: manual/periodic arbitration, fill, watering, cleaning and drain phases.
// Optional completed-cycle counter output enabled by defining SEQ_CONTADOR_CICLOS_EN.
module sequenciador_rega #(
  parameter int unsigned PERIODO_AUTO   = 60,
  parameter int unsigned T_ASPERSAO     = 10,
  parameter int unsigned T_GOTEJAMENTO  = 20,
  parameter int unsigned T_LIMPEZA      = 5,
  parameter int unsigned TIMEOUT_ENCHER = 30,
  parameter int unsigned TW             = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_manual,
  input  logic [1:0] manual_mode,
  input  logic       Nivel_cheio,
  input  logic       Vazio,
  input  logic       ack_erro,
  output logic [1:0] REGA_Mode,
  output logic       pedido_encher,
  output logic       busy,
  output logic       erro_timeout,
  output logic [2:0] estado
`ifdef SEQ_CONTADOR_CICLOS_EN
  ,
  output logic [7:0] ciclos
`endif
);

  localparam int unsigned CW = TW + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ENCHER   = 3'd1;
  localparam logic [2:0] S_REGAR    = 3'd2;
  localparam logic [2:0] S_LIMPAR   = 3'd3;
  localparam logic [2:0] S_ESVAZIAR = 3'd4;
  localparam logic [2:0] S_ERRO     = 3'd5;

  localparam logic [1:0] M_NONE = 2'b00;
  localparam logic [1:0] M_GOT  = 2'b01;
  localparam logic [1:0] M_ASP  = 2'b10;
  localparam logic [1:0] M_LIMP = 2'b11;

  localparam logic [TW-1:0] L_PER  = TW'(PERIODO_AUTO);
  localparam logic [CW-1:0] L_ASP  = CW'(T_ASPERSAO);
  localparam logic [CW-1:0] L_GOT  = CW'(T_GOTEJAMENTO);
  localparam logic [CW-1:0] L_LIMP = CW'(T_LIMPEZA);
  localparam logic [CW-1:0] L_TOUT = CW'(TIMEOUT_ENCHER);

  logic [2:0]    r_state, w_state_nx;
  logic [1:0]    r_mode, w_mode_nx;
  logic [TW-1:0] r_cnt, w_cnt_nx;
  logic [TW-1:0] r_per, w_per_nx;
  logic          r_pend, w_pend_nx;
  logic          r_alt, w_alt_nx;
  logic [1:0]    w_rm_nx;
  logic          w_ped_nx;
  logic          w_err_nx;
  logic          w_per_exp;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_lim_regar;

  assign w_per_exp   = tick && (r_per <= TW'(1));
  assign w_cnt_inc   = CW'(r_cnt) + CW'(1);
  assign w_lim_regar = (r_mode == M_ASP) ? L_ASP : L_GOT;

  // Next-state, phase timing, period arbitration and next registered outputs
  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_cnt_nx   = r_cnt;
    w_per_nx   = r_per;
    w_pend_nx  = r_pend;
    w_alt_nx   = r_alt;
    w_rm_nx    = M_NONE;
    w_ped_nx   = 1'b0;
    w_err_nx   = 1'b0;

    if (tick) begin
      if (w_per_exp) begin
        w_per_nx  = L_PER;
        w_pend_nx = 1'b1;
      end else begin
        w_per_nx = r_per - TW'(1);
      end
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (start_manual && (manual_mode != M_NONE)) begin
          w_mode_nx  = manual_mode;
          w_state_nx = (manual_mode == M_LIMP) ? S_LIMPAR : S_ENCHER;
          w_pend_nx  = 1'b0;
          w_per_nx   = L_PER;
        end else if (r_pend) begin
          w_mode_nx  = r_alt ? M_GOT : M_ASP;
          w_alt_nx   = ~r_alt;
          w_state_nx = S_ENCHER;
          // a fresh expiry on this same tick must not be lost
          w_pend_nx  = w_per_exp;
        end
      end
      S_ENCHER: begin
        if (Nivel_cheio) begin
          w_state_nx = S_REGAR;
          w_cnt_nx   = '0;
        end else if (tick) begin
          if (w_cnt_inc >= L_TOUT) begin
            w_state_nx = S_ERRO;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = w_cnt_inc[TW-1:0];
          end
        end
      end
      S_REGAR: begin
        if (Vazio) begin
          w_state_nx = S_LIMPAR;
          w_cnt_nx   = '0;
        end else if (tick) begin
          if (w_cnt_inc >= w_lim_regar) begin
            w_state_nx = S_LIMPAR;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = w_cnt_inc[TW-1:0];
          end
        end
      end
      S_LIMPAR: begin
        if (tick) begin
          if (w_cnt_inc >= L_LIMP) begin
            w_state_nx = S_ESVAZIAR;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = w_cnt_inc[TW-1:0];
          end
        end
      end
      S_ESVAZIAR: begin
        if (Vazio) w_state_nx = S_IDLE;
      end
      S_ERRO: begin
        w_cnt_nx = '0;
        if (ack_erro) w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase

    case (w_state_nx)
      S_ENCHER:               w_ped_nx = 1'b1;
      S_REGAR:                w_rm_nx  = w_mode_nx;
      S_LIMPAR, S_ESVAZIAR:   w_rm_nx  = M_LIMP;
      S_ERRO:                 w_err_nx = 1'b1;
      default:                w_rm_nx  = M_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mode        <= M_NONE;
      r_cnt         <= '0;
      r_per         <= L_PER;
      r_pend        <= 1'b0;
      r_alt         <= 1'b0;
      REGA_Mode     <= M_NONE;
      pedido_encher <= 1'b0;
      erro_timeout  <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_mode        <= w_mode_nx;
      r_cnt         <= w_cnt_nx;
      r_per         <= w_per_nx;
      r_pend        <= w_pend_nx;
      r_alt         <= w_alt_nx;
      REGA_Mode     <= w_rm_nx;
      pedido_encher <= w_ped_nx;
      erro_timeout  <= w_err_nx;
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign estado = r_state;

`ifdef SEQ_CONTADOR_CICLOS_EN
  // Completed cycles only: a drain that returns to IDLE; saturating
  logic [7:0] r_ciclos;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ciclos <= 8'd0;
    end else if ((r_state == S_ESVAZIAR) && (w_state_nx == S_IDLE) && (r_ciclos != 8'hFF)) begin
      r_ciclos <= r_ciclos + 8'd1;
    end
  end

  assign ciclos = r_ciclos;
`endif

endmodule

// File: tb/tb_sequenciador_rega.sv
// Directed table-driven bench for sequenciador_rega with short parameters, plus a drain-wait sequence.
module tb_sequenciador_rega;

  logic       clk = 1'b0;
  logic       reset, tick, start_manual, Nivel_cheio, Vazio, ack_erro;
  logic [1:0] manual_mode;
  logic [1:0] REGA_Mode;
  logic       pedido_encher, busy, erro_timeout;
  logic [2:0] estado;
`ifdef SEQ_CONTADOR_CICLOS_EN
  logic [7:0] ciclos;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sequenciador_rega #(
    .PERIODO_AUTO(4), .T_ASPERSAO(3), .T_GOTEJAMENTO(2),
    .T_LIMPEZA(2), .TIMEOUT_ENCHER(5), .TW(8)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_manual(start_manual),
    .manual_mode(manual_mode), .Nivel_cheio(Nivel_cheio), .Vazio(Vazio),
    .ack_erro(ack_erro), .REGA_Mode(REGA_Mode), .pedido_encher(pedido_encher),
    .busy(busy), .erro_timeout(erro_timeout), .estado(estado)
`ifdef SEQ_CONTADOR_CICLOS_EN
    , .ciclos(ciclos)
`endif
  );

  typedef struct {
    logic       rst, tk, sm;
    logic [1:0] mm;
    logic       nc, vz, ack;
    logic [2:0] est;
    logic [1:0] rm;
    logic       ped;
    logic [7:0] cic;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, tk, sm, input logic [1:0] mm,
                              input logic nc, vz, ack, input logic [2:0] est,
                              input logic [1:0] rm, input logic ped, input logic [7:0] cic);
    vec_t v;
    v.rst = rst; v.tk = tk; v.sm = sm; v.mm = mm; v.nc = nc; v.vz = vz; v.ack = ack;
    v.est = est; v.rm = rm; v.ped = ped; v.cic = cic;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic rst, tk, sm, input logic [1:0] mm, input logic nc, vz, ack);
    reset = rst; tick = tk; start_manual = sm; manual_mode = mm;
    Nivel_cheio = nc; Vazio = vz; ack_erro = ack;
    @(posedge clk);
    #1;
  endtask

  // Compares the full output bundle; busy and erro_timeout follow from the expected state
  task automatic check(input string name, input logic [2:0] est, input logic [1:0] rm,
                       input logic ped, input logic [7:0] cic);
    logic [7:0] act, exp;
    act = {estado, REGA_Mode, pedido_encher, busy, erro_timeout};
    exp = {est, rm, ped, (est != 3'd0), (est == 3'd5)};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {estado,mode,fill,busy,err}=%b want %b", name, act, exp);
    end
`ifdef SEQ_CONTADOR_CICLOS_EN
    n_checks++;
    if (ciclos !== cic) begin
      n_errors++;
      $display("FAIL %s ciclos: got %0d want %0d", name, ciclos, cic);
    end
`else
    if (cic == 8'hFF) $display("note: unexpected counter marker");
`endif
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start_manual = 1'b0; manual_mode = 2'b00;
    Nivel_cheio = 1'b0; Vazio = 1'b0; ack_erro = 1'b0;

    //   rst tk sm mm    nc vz ack  est   rm    ped cic
    add(1, 1, 0, 2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 0);   // reset
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 0); // period runs down
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd1, 2'b00, 1, 0);   // auto -> ENCHER
    add(0, 1, 0, 2'b00, 1, 0, 0, 3'd2, 2'b10, 0, 0);   // full -> REGAR aspersao
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd2, 2'b10, 0, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd2, 2'b10, 0, 0);   // auto expiry while busy
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd3, 2'b11, 0, 0);   // 3 ticks -> LIMPAR
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd3, 2'b11, 0, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd4, 2'b11, 0, 0);   // -> ESVAZIAR
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd4, 2'b11, 0, 0);   // waits for Vazio
    add(0, 1, 0, 2'b00, 0, 1, 0, 3'd0, 2'b00, 0, 1);   // -> IDLE
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd1, 2'b00, 1, 1);   // pending serviced next clk
    add(0, 1, 0, 2'b00, 1, 0, 0, 3'd2, 2'b01, 0, 1);   // alternates to gotejamento
    add(0, 1, 0, 2'b00, 0, 1, 0, 3'd3, 2'b11, 0, 1);   // early end on Vazio
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd3, 2'b11, 0, 1);
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd4, 2'b11, 0, 1);
    add(0, 1, 0, 2'b00, 0, 1, 0, 3'd0, 2'b00, 0, 2);
    add(0, 0, 1, 2'b01, 0, 0, 0, 3'd1, 2'b00, 1, 2);   // manual beats pending
    add(0, 0, 0, 2'b00, 1, 0, 0, 3'd2, 2'b01, 0, 2);
    add(0, 0, 0, 2'b00, 0, 1, 0, 3'd3, 2'b11, 0, 2);
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd3, 2'b11, 0, 2);
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd4, 2'b11, 0, 2);
    add(0, 1, 0, 2'b00, 0, 1, 0, 3'd0, 2'b00, 0, 3);
    add(0, 0, 0, 2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 3);   // pending was cleared
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 3);   // reloaded period expires now
    add(0, 0, 0, 2'b00, 0, 0, 0, 3'd1, 2'b00, 1, 3);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 2'b00, 0, 0, 0, 3'd1, 2'b00, 1, 3); // filling, no level
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd5, 2'b00, 0, 3);   // 5th tick -> ERRO
    add(0, 0, 0, 2'b00, 0, 0, 0, 3'd5, 2'b00, 0, 3);
    add(0, 0, 0, 2'b00, 0, 0, 1, 3'd0, 2'b00, 0, 3);   // ack -> IDLE, not counted
    add(0, 0, 0, 2'b00, 0, 0, 0, 3'd1, 2'b00, 1, 3);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 2'b00, 0, 0, 0, 3'd1, 2'b00, 1, 3);
    add(0, 1, 0, 2'b00, 1, 0, 0, 3'd2, 2'b01, 0, 3);   // full beats timeout
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd2, 2'b01, 0, 3);
    add(1, 1, 0, 2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 0);   // reset mid-REGAR
    add(0, 0, 1, 2'b11, 0, 0, 0, 3'd3, 2'b11, 0, 0);   // limpeza only
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd3, 2'b11, 0, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd4, 2'b11, 0, 0);
    add(0, 0, 0, 2'b00, 0, 1, 0, 3'd0, 2'b00, 0, 1);
    add(0, 0, 1, 2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 1);   // mode 00 ignored
    add(0, 0, 1, 2'b10, 0, 0, 0, 3'd1, 2'b00, 1, 1);
    add(0, 0, 1, 2'b01, 0, 0, 0, 3'd1, 2'b00, 1, 1);   // start while busy ignored
    add(0, 0, 0, 2'b00, 1, 0, 0, 3'd2, 2'b10, 0, 1);
    add(0, 0, 0, 2'b00, 0, 1, 0, 3'd3, 2'b11, 0, 1);
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd3, 2'b11, 0, 1);
    add(0, 1, 0, 2'b00, 0, 0, 0, 3'd4, 2'b11, 0, 1);
    add(0, 0, 0, 2'b00, 0, 1, 0, 3'd0, 2'b00, 0, 2);
    add(0, 0, 0, 2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 2);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].tk, tbl[i].sm, tbl[i].mm, tbl[i].nc, tbl[i].vz, tbl[i].ack);
      check($sformatf("vec%0d", i), tbl[i].est, tbl[i].rm, tbl[i].ped, tbl[i].cic);
    end

    // Long drain: ESVAZIAR has no timeout, expiries accumulate, serviced after return
    drive(0, 0, 1, 2'b10, 0, 0, 0);
    check("seq_enter", 3'd1, 2'b00, 1'b1, 8'd2);
    drive(0, 0, 0, 2'b00, 1, 0, 0);
    check("seq_regar", 3'd2, 2'b10, 1'b0, 8'd2);
    begin
      int k;
      k = 0;
      while (estado != 3'd4 && k < 20) begin
        drive(0, 1, 0, 2'b00, 0, 0, 0);
        k++;
      end
      n_checks++;
      if (estado != 3'd4 || k != 5) begin
        n_errors++;
        $display("FAIL seq_reach_drain: estado=%0d after %0d clks, want 4 after 5", estado, k);
      end
    end
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, 0, 2'b00, 0, 0, 0);
      check($sformatf("seq_hold%0d", i), 3'd4, 2'b11, 1'b0, 8'd2);
    end
    drive(0, 0, 0, 2'b00, 0, 1, 0);
    check("seq_idle", 3'd0, 2'b00, 1'b0, 8'd3);
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    check("seq_auto", 3'd1, 2'b00, 1'b1, 8'd3);
    drive(0, 0, 0, 2'b00, 1, 0, 0);
    check("seq_auto_mode", 3'd2, 2'b10, 1'b0, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sequenciador_rega.md
Name: sequenciador_rega

Overview:
- Cycle scheduler for the automatic irrigation datapath.
- Decides when a watering cycle runs, requests tank fill, drives the REGA_Mode selection for the irrigation controller, times each phase, and ends every cycle with a cleaning/drain phase.
- Arbitrates between a manual start button and an internal periodic timer; both share the single tank/valve resource.
- Sits between the user inputs and the fill/watering controllers, clocked from the system clk with a 1-cycle-wide `tick` time base.

Parameters:
- PERIODO_AUTO, 60, ticks between automatic cycle requests (must be ≥1)
- T_ASPERSAO, 10, ticks of sprinkler phase
- T_GOTEJAMENTO, 20, ticks of drip phase
- T_LIMPEZA, 5, ticks of cleaning phase
- TIMEOUT_ENCHER, 30, max ticks allowed for fill before error
- TW, 8, width of internal tick counters

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  time-base enable, one clk cycle wide; all durations count ticks
- start_manual  in  1  manual cycle request, level sampled each clk
- manual_mode  in  2  mode for a manual cycle: 00 none, 01 gotejamento, 10 aspersao, 11 limpeza only
- Nivel_cheio  in  1  tank full
- Vazio  in  1  tank empty
- ack_erro  in  1  clears error state
- REGA_Mode  out  2  mode to irrigation controller, same encoding as manual_mode
- pedido_encher  out  1  request fill valve
- busy  out  1  cycle in progress (state ≠ IDLE)
- erro_timeout  out  1  fill timeout error flag
- estado  out  3  current state code, for display/debug

Behaviour:
- States and codes:
  - IDLE=0, ENCHER=1, REGAR=2, LIMPAR=3, ESVAZIAR=4, ERRO=5.
  - Registered; transitions take effect on the clk edge after the condition is true.
- Reset values:
  - State IDLE; all outputs 0.
  - Phase counter 0; period counter loaded with PERIODO_AUTO.
  - pending_auto=0; alterna=0.
- Period counter:
  - Decrements on tick in every state.
  - On tick at value 1, sets pending_auto=1 and reloads PERIODO_AUTO (wrap-around, never reaches 0).
- IDLE exits, in priority order:
  - start_manual with manual_mode≠00 → takes the manual mode.
    - mode 11 → LIMPAR.
    - otherwise → ENCHER.
    - Clears pending_auto and reloads the period counter.
  - Else pending_auto=1 → ENCHER with mode 10 if alterna=0, else 01. Toggles alterna and clears pending_auto.
  - start_manual with manual_mode=00 is ignored.
- Requests outside IDLE:
  - start_manual while busy is ignored (not queued).
  - An automatic expiry while busy sets pending_auto, which is serviced on return to IDLE.
- Mode latching: the selected mode is stored in a register at IDLE exit and held for the whole cycle.
- ENCHER:
  - pedido_encher=1; REGA_Mode=00; phase counter counts ticks from 0.
  - Nivel_cheio → REGAR, with the counter cleared.
  - Counter reaching TIMEOUT_ENCHER before full → ERRO.
  - If Nivel_cheio and the timeout occur in the same cycle, Nivel_cheio wins.
- REGAR:
  - REGA_Mode=latched mode; pedido_encher=0.
  - Exits to LIMPAR, counter cleared, when the counter reaches T_ASPERSAO (mode 10) or T_GOTEJAMENTO (mode 01).
  - Vazio=1 during REGAR → LIMPAR immediately (early end).
- LIMPAR:
  - REGA_Mode=11; exits to ESVAZIAR when the counter reaches T_LIMPEZA.
- ESVAZIAR:
  - REGA_Mode=11; waits for Vazio=1, then → IDLE.
  - No timeout.
- ERRO:
  - erro_timeout=1; REGA_Mode=00; pedido_encher=0.
  - ack_erro=1 → IDLE.
  - pending_auto is still accumulated but not serviced until IDLE.
- Outputs: busy and estado are combinational from the state register; REGA_Mode and pedido_encher are registered alongside the state.
- Counter width: phase counter is TW bits; comparisons use ≥ so parameters up to 2^TW−1 are valid.
- Reset mid-cycle: returns to IDLE on the next edge; all outputs 0 that same edge; no partial phase resumes.

Optional Feature:
- Macro: SEQ_CONTADOR_CICLOS_EN.
- When defined:
  - Adds output port ciclos [7:0], the count of completed cycles.
  - Increments on each ESVAZIAR→IDLE transition, saturates at 255, reset to 0.
  - ERRO exits do not count.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Auto cycle (PERIODO_AUTO=4, T_ASPERSAO=3, tick every clk) → ENCHER after 4 ticks with REGA_Mode=00 and pedido_encher=1; Nivel_cheio → REGAR with REGA_Mode=10 for 3 ticks, LIMPAR 11, ESVAZIAR; Vazio → IDLE. The next auto cycle uses REGA_Mode=01.
- Simultaneous start_manual (mode 01) and auto expiry in IDLE → manual wins, REGA_Mode=01 in REGAR, pending_auto=0, period reloaded.
- Auto expiry during REGAR → cycle finishes unchanged; ENCHER re-entered 1 clk after returning to IDLE.
- Fill timeout (TIMEOUT_ENCHER=5, Nivel_cheio held 0) → ERRO after 5 ticks with erro_timeout=1; ack_erro → IDLE with erro_timeout=0.
- manual_mode=11 in IDLE → LIMPAR directly without ENCHER; manual_mode=00 → stays IDLE.
- Reset asserted in REGAR → next edge estado=0, REGA_Mode=00, busy=0; with SEQ_CONTADOR_CICLOS_EN, ciclos=0 and it reaches 2 after two complete cycles.
